// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared types and helpers for the register-bank write arbiter
package regarb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Widest address the select decoder supports (256 registers).
    localparam int MAX_A = 8;

    function automatic int nreg(input int a);
        return 1 << a;
    endfunction

    function automatic logic [(1 << MAX_A)-1:0] onehot_dec(input logic [MAX_A-1:0] idx);
        onehot_dec      = '0;
        onehot_dec[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner search; REGARB_FIXED_PRIO_EN selects fixed lowest-index priority
module rr_pick
    import regarb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] win_o,
    output logic         valid_o
);

`ifdef REGARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o = 1'b1;
                win_o   = W'(i);
            end
        end
    end
`else
    int idx;

    // Scan N slots starting at the pointer, wrapping N-1 -> 0.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                win_o   = W'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - N-requester write arbiter for a 2**A register bank
// Build option: REGARB_FIXED_PRIO_EN (fixed lowest-index priority, no rr pointer).
module regbank_write_arbiter
    import regarb_pkg::*;
#(
    parameter int A = 3,
    parameter int D = 8,
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*A-1:0]  addr,
    input  logic [N*D-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [2**A-1:0] sel,
    output logic [D-1:0]    wr_data,
    output logic            busy
);

    localparam int NREG = nreg(A);
    localparam int W    = (N > 1) ? $clog2(N) : 1;

    state_e          state_q;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [NREG-1:0] sel_q, sel_d;
    logic [D-1:0]    wr_data_q, wr_data_d;
    logic [W-1:0]    ptr_q, ptr_d;
    logic [W-1:0]    win;
    logic            win_valid;
    logic [A-1:0]    addr_w;

    rr_pick #(
        .N(N),
        .W(W)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .win_o  (win),
        .valid_o(win_valid)
    );

    // Only the winner's slice reaches the bank; other requesters are ignored.
    always_comb begin
        addr_w    = '0;
        wr_data_d = '0;
        for (int i = 0; i < N; i++) begin
            if (win == W'(i)) begin
                addr_w    = addr[i*A +: A];
                wr_data_d = wdata[i*D +: D];
            end
        end
    end

    assign gnt_d = N'(1) << win;
    assign sel_d = NREG'(onehot_dec(MAX_A'(addr_w)));

`ifdef REGARB_FIXED_PRIO_EN
    assign ptr_d = '0;
`else
    assign ptr_d = (win == W'(N-1)) ? '0 : win + W'(1);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            wr_data_q <= '0;
            ptr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q   <= WRITE;
                        gnt_q     <= gnt_d;
                        sel_q     <= sel_d;
                        wr_data_q <= wr_data_d;
                        ptr_q     <= ptr_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    gnt_q     <= '0;
                    sel_q     <= '0;
                    wr_data_q <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == WRITE);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - self-checking bench for regbank_write_arbiter
module tb_regbank_write_arbiter;

    localparam int A = 3;
    localparam int D = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*A-1:0] addr;
    logic [N*D-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [7:0]     sel;
    logic [D-1:0]   wr_data;
    logic           busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int m_ptr     = 0;
    bit m_busy    = 1'b0;

    always #5 clk = ~clk;

    regbank_write_arbiter #(.A(A), .D(D), .N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .sel    (sel),
        .wr_data(wr_data),
        .busy   (busy)
    );

    typedef struct {
        logic [N-1:0]   req;
        logic [N*A-1:0] addr;
        logic [N*D-1:0] wdata;
        logic [N-1:0]   g;
        logic [7:0]     s;
        logic [D-1:0]   w;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] eg, input logic [7:0] es,
                              input logic [D-1:0] ew, input logic eb);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".sel"}, 32'(sel), 32'(es));
        check({tag, ".wr_data"}, 32'(wr_data), 32'(ew));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    // Reference: a write takes one cycle after an idle cycle; the first requester
    // at or after the pointer (or lowest index in fixed-priority builds) wins.
    task automatic tick_check(input string tag);
        logic [N-1:0] eg;
        logic [7:0]   es;
        logic [D-1:0] ew;
        logic         eb;
        int           w;
        eg = '0; es = '0; ew = '0; eb = 1'b0; w = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i;
`ifdef REGARB_FIXED_PRIO_EN
                i = k;
`else
                i = (m_ptr + k) % N;
`endif
                if (w < 0 && req[i]) w = i;
            end
            if (w >= 0) begin
                logic [N*A-1:0] at;
                logic [N*D-1:0] dt;
                at = addr >> (w * A);
                dt = wdata >> (w * D);
                eb = 1'b1;
                eg = N'(1) << w;
                es = 8'(1) << at[A-1:0];
                ew = dt[D-1:0];
                m_ptr = (w + 1) % N;
            end
        end
        m_busy = eb;
        @(posedge clk); #1;
        check_outs(tag, eg, es, ew, eb);
    endtask

    task automatic wait_gnt(input string tag, output int who);
        who = -1;
        for (int c = 0; c < 12 && who < 0; c++) begin
            tick_check(tag);
            for (int i = 0; i < N; i++) if (gnt[i]) who = i;
        end
        if (who < 0) check({tag, ".timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_ptr = 0;
        m_busy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    vec_t vt[5];
    int   who;

    initial begin
        reset = 1'b0; req = '0; addr = '0; wdata = '0;

        // Reset held with every requester asking
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_outs("in_reset", 4'b0, 8'b0, 8'h00, 1'b0);
        end
        reset = 1'b1;
        wait_gnt("first_after_reset", who);
        check("first_winner", 32'(who), 32'd0);
        req = '0;
        tick_check("first_after_reset.idle");

        // Table-driven single writes, each from a freshly reset arbiter
        vt[0] = '{4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, {8'h00, 8'hA5, 8'h00, 8'h00}, 4'b0100, 8'b0010_0000, 8'hA5};
        vt[1] = '{4'b1111, {3'd1, 3'd2, 3'd3, 3'd6}, {8'h44, 8'h33, 8'h22, 8'h11}, 4'b0001, 8'b0100_0000, 8'h11};
        vt[2] = '{4'b1000, {3'd7, 3'd2, 3'd3, 3'd6}, {8'hFF, 8'h33, 8'h22, 8'h11}, 4'b1000, 8'b1000_0000, 8'hFF};
        vt[3] = '{4'b0000, {3'd7, 3'd2, 3'd3, 3'd6}, {8'hFF, 8'h33, 8'h22, 8'h11}, 4'b0000, 8'b0000_0000, 8'h00};
        vt[4] = '{4'b1010, {3'd4, 3'd2, 3'd0, 3'd6}, {8'h99, 8'h33, 8'h3C, 8'h11}, 4'b0010, 8'b0000_0001, 8'h3C};
        for (int v = 0; v < 5; v++) begin
            do_reset();
            req = vt[v].req; addr = vt[v].addr; wdata = vt[v].wdata;
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", v), vt[v].g, vt[v].s, vt[v].w, |vt[v].g);
            req = '0;
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d.idle", v), 4'b0, 8'b0, 8'h00, 1'b0);
        end

        // Grant order with everyone requesting, then pointer wrap to 0
        do_reset();
        addr = {3'd3, 3'd2, 3'd1, 3'd0};
        wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req = 4'b1111;
        for (int n = 0; n < N; n++) begin
            wait_gnt("rr", who);
            check("rr_order", 32'(who), 32'(n));
            if (who >= 0) req[who] = 1'b0;
        end
        req = 4'b1001;
        wait_gnt("wrap", who);
        check("wrap_first", 32'(who), 32'd0);
        if (who >= 0) req[who] = 1'b0;
        wait_gnt("wrap", who);
        check("wrap_second", 32'(who), 32'd3);
        req = '0;
        tick_check("wrap.idle");

        // Data changed during WRITE must not disturb the current write
        do_reset();
        addr = {3'd0, 3'd5, 3'd0, 3'd0};
        wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
        req = 4'b0100;
        tick_check("midwrite");
        wdata[23:16] = 8'h00;
        addr[8:6] = 3'd1;
        req = '0;
        #2;
        check("midwrite.hold", 32'(wr_data), 32'hA5);
        check("midwrite.sel_hold", 32'(sel), 32'h20);
        @(posedge clk); #1;
        m_busy = 1'b0;
        tick_check("midwrite.no_req");
        req = 4'b0100;
        tick_check("midwrite.reassert");
        check("midwrite.new_data", 32'(wr_data), 32'h00);
        req = '0;
        tick_check("midwrite.end");

        // Asynchronous reset in the middle of a write
        do_reset();
        req = 4'b0010;
        tick_check("async.write");
        #2;
        reset = 1'b0;
        #1;
        check_outs("async.cleared", 4'b0, 8'b0, 8'h00, 1'b0);
        m_ptr = 0; m_busy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        req = 4'b1111;
        wait_gnt("async.after", who);
        check("async.ptr0", 32'(who), 32'd0);
        req = '0;
        tick_check("async.idle");

        // Requesters 1 and 3 repeatedly reasserted
        do_reset();
        for (int r = 0; r < 4; r++) begin
            req = 4'b1010;
            wait_gnt("prio", who);
`ifdef REGARB_FIXED_PRIO_EN
            check("prio_winner", 32'(who), 32'd1);
`else
            check("prio_winner", 32'(who), (r % 2 == 0) ? 32'd1 : 32'd3);
`endif
        end
        req = 4'b1000;
        wait_gnt("prio.only3", who);
        check("prio_only3", 32'(who), 32'd3);
        req = '0;
        tick_check("prio.idle");

        // Randomised traffic: requesters hold until granted, data churns meanwhile
        do_reset();
        req = '0;
        for (int c = 0; c < 400; c++) begin
            tick_check("rand");
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    req[i] = 1'b0;
                    addr[i*A +: A] = A'($urandom);
                    wdata[i*D +: D] = D'($urandom);
                end else if (!req[i]) begin
                    addr[i*A +: A] = A'($urandom);
                    wdata[i*D +: D] = D'($urandom);
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
